pipe_branch_unit: RTL and testbench
===================================

Name: pipe_branch_unit

Overview:
Parametrised successor to the pipeline's PC-relative target adder. Resolves the next PC for conditional branches, absolute jumps and register jumps, and evaluates the branch condition. The result is held in one registered stage with a valid/ready handshake and a flush input. Sits between ID/EX operand delivery and the IF-stage PC mux.

Parameters:
AW, 32, address/data width (>=8).
IMM_W, 16, branch immediate width; sign-extended to AW.
JIDX_W, 26, jump index width; must satisfy JIDX_W+SHIFT <= AW.
SHIFT, 2, left shift applied to imm and jump index (word alignment).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of held and incoming op.
in_valid  in  1  op presented.
in_ready  out  1  stage can accept.
mode  in  2  00 BR (conditional rel), 01 J (absolute), 10 JR (register), 11 NOP.
cond  in  3  BR only: 000 EQ, 001 NE, 010 LEZ, 011 GTZ, 100 LTZ, 101 GEZ, others never-taken.
pc  in  AW  PC of the delay-slot/next instruction (already PC+4).
imm  in  IMM_W  branch offset in words.
jidx  in  JIDX_W  jump index.
rs  in  AW  operand A / JR target.
rt  in  AW  operand B (EQ/NE only).
out_valid  out  1  result held.
out_ready  in  1  consumer accepts.
taken  out  1  redirect required.
next_pc  out  AW  taken ? target : pc.
target  out  AW  computed target regardless of taken.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, taken=0, next_pc=0, target=0. Deassertion is synchronised by the integrator; the block needs no reset-release logic.
- in_ready = !out_valid || out_ready (combinational; no dependency on in_valid).
- Accept on in_valid && in_ready && !flush. Outputs register on the next rising edge; latency 1 cycle.
- Hold: while out_valid && !out_ready, all outputs stay stable.
- Pop without a new accept: out_valid falls; data outputs keep their last values.
- Simultaneous pop and accept: new result loads; out_valid stays 1.
- flush: next edge forces out_valid=0 and discards any concurrent accept. Flush has priority over everything except reset.
- Target arithmetic (modulo 2^AW, wrap-around silently ignored):
  - BR: pc + (sext(imm) << SHIFT).
  - J: {pc[AW-1:JIDX_W+SHIFT], jidx, SHIFT'b0}.
  - JR: rs.
  - NOP: pc.
- Taken:
  - BR: cond evaluated on signed rs (and rt for EQ/NE).
  - J, JR: always 1.
  - NOP: always 0.
- Reserved cond in BR: taken=0; target is still computed.
- Reset mid-hold: result is dropped; no replay.

Optional Feature:
Macro PIPE_BRANCH_STATS_EN.
- Defined:
  - Adds output ports br_count[31:0] and br_taken_count[31:0].
  - br_count increments on every accepted BR op; br_taken_count increments when that BR op is also taken.
  - Counters update on the accept edge, saturate at 0xFFFFFFFF, clear on reset, and are not affected by flush of an already-accepted op.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_branch_pkg:
  - mode encodings MODE_BR/J/JR/NOP.
  - cond encodings COND_EQ..COND_GEZ.
  - function sext_shift(imm).
- Sub-module pipe_branch_cond: combinational condition evaluator (cond, rs, rt) -> taken_br.
- Target mux, handshake register and stats counters stay in the top.

Test Plan:
- Backward BR EQ: pc=0x00400004, imm=0xFFFF, rs=rt=5 -> one cycle later out_valid=1, taken=1, target=next_pc=0x00400000.
- Not-taken BR NE: pc=0x00400004, imm=0x0003, rs=rt=7 -> target=0x00400010, taken=0, next_pc=0x00400004.
- J: pc=0xA0000008, jidx=0x0100000 -> target=0xA0400000, taken=1. JR: rs=0x00400123 -> target=next_pc=0x00400123.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Raise out_ready -> back-to-back transfer with out_valid staying 1 across the swap.
- flush while out_valid=1 and a new op is presented -> out_valid=0 next cycle and the op is dropped. Async rst_n low mid-hold -> outputs zero immediately.
- Wrap and signs: pc=0xFFFFFFFC, imm=0x0002 -> target=0x00000004. BR LTZ rs=0x80000000 -> taken=1; BR GTZ rs=0 -> taken=0. With PIPE_BRANCH_STATS_EN: br_count=2, br_taken_count=1 after these two ops.

Source files
------------

// File: rtl/pipe_branch_pkg.sv
// Shared encodings and immediate helper for the pipeline branch unit.
package pipe_branch_pkg;

    typedef enum logic [1:0] {
        MODE_BR  = 2'b00,
        MODE_J   = 2'b01,
        MODE_JR  = 2'b10,
        MODE_NOP = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        COND_EQ  = 3'b000,
        COND_NE  = 3'b001,
        COND_LEZ = 3'b010,
        COND_GTZ = 3'b011,
        COND_LTZ = 3'b100,
        COND_GEZ = 3'b101
    } cond_e;

    // Sign-extends the low imm_w bits of imm to 64 bits, then shifts left; callers truncate to AW (AW <= 64).
    function automatic logic [63:0] sext_shift(input logic [63:0] imm, input int imm_w, input int shift);
        logic [63:0] ext;
        ext = imm << (64 - imm_w);
        ext = $signed(ext) >>> (64 - imm_w);
        return ext << shift;
    endfunction

endpackage

// File: rtl/pipe_branch_cond.sv
// Combinational branch condition evaluator; rs/rt are compared as signed values.
module pipe_branch_cond
    import pipe_branch_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [2:0]    cond_i,
    input  logic [AW-1:0] rs_i,
    input  logic [AW-1:0] rt_i,
    output logic          taken_br_o
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_i[AW-1];
    assign rs_zero = (rs_i == '0);

    always_comb begin
        taken_br_o = 1'b0;
        case (cond_i)
            COND_EQ:  taken_br_o = (rs_i == rt_i);
            COND_NE:  taken_br_o = (rs_i != rt_i);
            COND_LEZ: taken_br_o = rs_neg || rs_zero;
            COND_GTZ: taken_br_o = !rs_neg && !rs_zero;
            COND_LTZ: taken_br_o = rs_neg;
            COND_GEZ: taken_br_o = !rs_neg;
            default:  taken_br_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_branch_unit.sv
// Next-PC resolver with one registered valid/ready stage and flush.
// Optional branch statistics counters enabled by PIPE_BRANCH_STATS_EN.
module pipe_branch_unit
    import pipe_branch_pkg::*;
#(
    parameter int AW     = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic [2:0]        cond,
    input  logic [AW-1:0]     pc,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [AW-1:0]     rs,
    input  logic [AW-1:0]     rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              taken,
    output logic [AW-1:0]     next_pc,
    output logic [AW-1:0]     target
`ifdef PIPE_BRANCH_STATS_EN
    ,
    output logic [31:0]       br_count,
    output logic [31:0]       br_taken_count
`endif
);

    // Clears the upper PC bits that the jump index replaces; zero when the index fills the word.
    localparam logic [AW-1:0] J_HI_MASK = ~((AW'(1) << (JIDX_W + SHIFT)) - AW'(1));

    // Handshake: a transfer happens on a rising edge where valid && ready; an
    // offered op may not be withdrawn, and a held result stays stable until popped.
    logic          valid_q, valid_d;
    logic          taken_q, taken_d;
    logic [AW-1:0] next_pc_q, next_pc_d;
    logic [AW-1:0] target_q, target_d;

    logic          taken_br;
    logic          accept;
    logic [AW-1:0] br_off;
    logic [AW-1:0] j_lo;
    logic          op_taken;
    logic [AW-1:0] op_target;

    pipe_branch_cond #(.AW(AW)) u_cond (
        .cond_i     (cond),
        .rs_i       (rs),
        .rt_i       (rt),
        .taken_br_o (taken_br)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign br_off   = AW'(sext_shift(64'(imm), IMM_W, SHIFT));
    assign j_lo     = AW'(jidx) << SHIFT;

    always_comb begin
        op_taken  = 1'b0;
        op_target = pc;
        case (mode)
            MODE_BR: begin
                op_taken  = taken_br;
                op_target = pc + br_off;
            end
            MODE_J: begin
                op_taken  = 1'b1;
                op_target = (pc & J_HI_MASK) | j_lo;
            end
            MODE_JR: begin
                op_taken  = 1'b1;
                op_target = rs;
            end
            default: begin
                op_taken  = 1'b0;
                op_target = pc;
            end
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        taken_d   = taken_q;
        next_pc_d = next_pc_q;
        target_d  = target_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            taken_d   = op_taken;
            next_pc_d = op_taken ? op_target : pc;
            target_d  = op_target;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            taken_q   <= 1'b0;
            next_pc_q <= '0;
            target_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            taken_q   <= taken_d;
            next_pc_q <= next_pc_d;
            target_q  <= target_d;
        end
    end

    assign out_valid = valid_q;
    assign taken     = taken_q;
    assign next_pc   = next_pc_q;
    assign target    = target_q;

`ifdef PIPE_BRANCH_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] br_tk_q, br_tk_d;
    logic        br_accept;

    assign br_accept = accept && (mode == MODE_BR);

    always_comb begin
        br_cnt_d = br_cnt_q;
        br_tk_d  = br_tk_q;
        if (br_accept && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
        if (br_accept && taken_br && (br_tk_q != 32'hFFFF_FFFF)) br_tk_d = br_tk_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            br_tk_q  <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            br_tk_q  <= br_tk_d;
        end
    end

    assign br_count       = br_cnt_q;
    assign br_taken_count = br_tk_q;
`endif

endmodule

// File: tb/tb_pipe_branch_unit.sv
// Directed-vector scoreboard bench for pipe_branch_unit.
module tb_pipe_branch_unit;
    import pipe_branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  mode = 2'b11;
    logic [2:0]  cond = 3'b000;
    logic [31:0] pc = '0;
    logic [15:0] imm = '0;
    logic [25:0] jidx = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] target;
`ifdef PIPE_BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] br_taken_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];

    pipe_branch_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .cond      (cond),
        .pc        (pc),
        .imm       (imm),
        .jidx      (jidx),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .next_pc   (next_pc),
        .target    (target)
`ifdef PIPE_BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .br_taken_count (br_taken_count)
`endif
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] res(input logic tk, input logic [31:0] np, input logic [31:0] tg);
        return {tk, np, tg};
    endfunction

    // Scoreboard monitor: a result transfers on the next edge whenever valid && ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%h expected=none", {taken, next_pc, target});
            end else begin
                chk("result", {taken, next_pc, target}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_op(input logic [1:0] m, input logic [2:0] c, input logic [31:0] p,
                          input logic [15:0] i, input logic [25:0] j,
                          input logic [31:0] a, input logic [31:0] b);
        mode = m;
        cond = c;
        pc   = p;
        imm  = i;
        jidx = j;
        rs   = a;
        rt   = b;
    endtask

    task automatic issue(input logic [1:0] m, input logic [2:0] c, input logic [31:0] p,
                         input logic [15:0] i, input logic [25:0] j,
                         input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        set_op(m, c, p, i, j, a, b);
        in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 65'd0, 65'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", 65'(out_valid), 65'd0);
        chk("reset_data", {taken, next_pc, target}, res(1'b0, 32'h0, 32'h0));
        chk("reset_in_ready", 65'(in_ready), 65'd1);
        @(posedge clk);
        #1;

        // Basic resolves with the consumer always ready
        exp_q.push_back(res(1'b1, 32'h0040_0000, 32'h0040_0000));
        issue(MODE_BR, COND_EQ, 32'h0040_0004, 16'hFFFF, '0, 32'd5, 32'd5);
        exp_q.push_back(res(1'b0, 32'h0040_0004, 32'h0040_0010));
        issue(MODE_BR, COND_NE, 32'h0040_0004, 16'h0003, '0, 32'd7, 32'd7);
        exp_q.push_back(res(1'b1, 32'hA040_0000, 32'hA040_0000));
        issue(MODE_J, 3'd0, 32'hA000_0008, 16'h0, 26'h010_0000, 32'h0, 32'h0);
        exp_q.push_back(res(1'b1, 32'h0040_0123, 32'h0040_0123));
        issue(MODE_JR, 3'd0, 32'h0000_1000, 16'h0, '0, 32'h0040_0123, 32'h0);
        exp_q.push_back(res(1'b0, 32'h1234_5678, 32'h1234_5678));
        issue(MODE_NOP, 3'd0, 32'h1234_5678, 16'h7FFF, 26'h3FF_FFFF, 32'hDEAD_BEEF, 32'h0);
        exp_q.push_back(res(1'b1, 32'h0000_0004, 32'h0000_0004));
        issue(MODE_BR, COND_EQ, 32'hFFFF_FFFC, 16'h0002, '0, 32'h0, 32'h0);
        exp_q.push_back(res(1'b0, 32'h0000_0300, 32'h0000_0304));
        issue(MODE_BR, 3'b110, 32'h0000_0300, 16'h0001, '0, 32'h0, 32'h0);
        idle(1);

        // Backpressure: X held for three cycles while Y waits, then back-to-back swap
        out_ready = 1'b0;
        exp_q.push_back(res(1'b1, 32'h0000_1010, 32'h0000_1010));
        issue(MODE_BR, COND_GEZ, 32'h0000_1000, 16'h0004, '0, 32'h1, 32'h0);
        set_op(MODE_BR, COND_LEZ, 32'h0000_2000, 16'hFFFC, '0, 32'hFFFF_FFFF, 32'h0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_in_ready", 65'(in_ready), 65'd0);
            chk("hold_data", {out_valid, taken, next_pc, target}, {1'b1, 1'b1, 32'h0000_1010, 32'h0000_1010});
            @(posedge clk);
            #1;
        end
        exp_q.push_back(res(1'b1, 32'h0000_1FF0, 32'h0000_1FF0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("swap_valid", 65'(out_valid), 65'd1);
        @(posedge clk);
        #1;

        // Flush kills the held op and a concurrently offered op
        out_ready = 1'b0;
        issue(MODE_J, 3'd0, 32'h0000_4000, 16'h0, 26'h000_0040, 32'h0, 32'h0);
        set_op(MODE_BR, COND_EQ, 32'h0000_5000, 16'h0001, '0, 32'h0, 32'h0);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 65'(out_valid), 65'd0);
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset while a result is held
        out_ready = 1'b0;
        issue(MODE_JR, 3'd0, 32'h0000_6000, 16'h0, '0, 32'h0000_7777, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_hold_valid", 65'(out_valid), 65'd0);
        chk("rst_hold_data", {taken, next_pc, target}, res(1'b0, 32'h0, 32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Sign checks, then pop without a new accept
        exp_q.push_back(res(1'b1, 32'h0000_0104, 32'h0000_0104));
        issue(MODE_BR, COND_LTZ, 32'h0000_0100, 16'h0001, '0, 32'h8000_0000, 32'h0);
        exp_q.push_back(res(1'b0, 32'h0000_0200, 32'h0000_0240));
        issue(MODE_BR, COND_GTZ, 32'h0000_0200, 16'h0010, '0, 32'h0, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("pop_valid", 65'(out_valid), 65'd0);
        chk("pop_keep_data", {taken, next_pc, target}, res(1'b0, 32'h0000_0200, 32'h0000_0240));
`ifdef PIPE_BRANCH_STATS_EN
        chk("br_count", 65'(br_count), 65'd2);
        chk("br_taken_count", 65'(br_taken_count), 65'd1);
`endif

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
        chk("drain_queue", 65'(exp_q.size()), 65'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
